// File: rtl/rm_stage_sequencer.sv
// Sequencer and report scheduler for one runtime-monitor automata stage:
// feeds symbols to the stage, captures its report wires, and serializes
// each captured vector as one report ID per handshake.
module rm_stage_sequencer #(
  parameter int unsigned NUM_REPORTS = 20,
  parameter int unsigned ID_W        = 5,
  parameter int unsigned SYM_W       = 8,
  parameter int unsigned REPORT_LAT  = 1,
  parameter int unsigned PEND_DEPTH  = 4,
  parameter int unsigned RST_CYC     = 2,
  parameter int unsigned SEQ_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym_data,
  input  logic                   sym_last,
  output logic                   sym_ready,
  input  logic                   flush_req,
  output logic                   auto_run,
  output logic                   auto_reset,
  output logic [SYM_W-1:0]       auto_symbols,
  input  logic [NUM_REPORTS-1:0] auto_reports,
  output logic                   rpt_valid,
  output logic [ID_W-1:0]        rpt_id,
  output logic [SEQ_W-1:0]       rpt_seq,
  input  logic                   rpt_ready,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(PEND_DEPTH + 1);
  localparam int unsigned RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int unsigned INF_W = $clog2(REPORT_LAT + 2);

  typedef enum logic [1:0] {ST_FLUSH, ST_STREAM, ST_DRAIN} state_e;

  typedef struct packed {
    logic [NUM_REPORTS-1:0] vec;
    logic [SEQ_W-1:0]       tag;
  } pend_t;

  state_e                  state_q, state_d;
  logic [RC_W-1:0]         rcnt_q, rcnt_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic                    auto_run_q, auto_run_d;
  logic [SYM_W-1:0]        sym_q, sym_d;
  logic [SEQ_W-1:0]        tag_q, tag_d;
  logic [REPORT_LAT-1:0]   run_sr_q, run_sr_d;
  logic [SEQ_W-1:0]        tag_sr_q [REPORT_LAT];
  logic [SEQ_W-1:0]        tag_sr_d [REPORT_LAT];
  pend_t                   q_q [PEND_DEPTH];
  pend_t                   q_d [PEND_DEPTH];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sym_ready_q, sym_ready_d;
  logic                    auto_reset_q, auto_reset_d;
  logic                    rpt_valid_q, rpt_valid_d;
  logic [ID_W-1:0]         rpt_id_q, rpt_id_d;
  logic [SEQ_W-1:0]        rpt_seq_q, rpt_seq_d;
  logic                    busy_q, busy_d;
  logic [INF_W-1:0]        infl_now, infl_d;
  logic [NUM_REPORTS-1:0]  head_vec;
  logic                    accept, rpt_hs, push;

  // Number of symbols whose reports have not been sampled yet.
  function automatic logic [INF_W-1:0] run_count(input logic run,
                                                 input logic [REPORT_LAT-1:0] sr);
    logic [INF_W-1:0] n;
    n = INF_W'(run);
    for (int i = 0; i < REPORT_LAT; i++) n = n + INF_W'(sr[i]);
    return n;
  endfunction

  // Fixed-priority pick: lowest set report bit.
  function automatic logic [ID_W-1:0] low_bit(input logic [NUM_REPORTS-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NUM_REPORTS - 1; i >= 0; i--) if (v[i]) id = ID_W'(i);
    return id;
  endfunction

  assign accept   = sym_valid && sym_ready_q;
  assign rpt_hs   = rpt_valid_q && rpt_ready;
  assign push     = run_sr_q[REPORT_LAT-1] && (auto_reports != '0);
  assign infl_now = run_count(auto_run_q, run_sr_q);

  // Next-state logic: FSM, run pipeline, pending queue and registered outputs.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    seq_d    = seq_q;
    auto_run_d = accept;
    sym_d    = accept ? sym_data : sym_q;
    tag_d    = seq_q;
    run_sr_d = run_sr_q;
    tag_sr_d = tag_sr_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    head_vec = '0;

    case (state_q)
      ST_FLUSH: begin
        seq_d = '0;
        if (rcnt_q == RC_W'(RST_CYC - 1)) begin
          state_d = ST_STREAM;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      ST_STREAM: begin
        if (accept) seq_d = seq_q + SEQ_W'(1);
        if ((accept && sym_last) || flush_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (infl_now == '0 && cnt_q == '0) begin
          state_d = ST_FLUSH;
          rcnt_d  = '0;
        end
      end
      default: state_d = ST_FLUSH;
    endcase

    // Tags travel alongside the run strobe until the reports are sampled.
    run_sr_d[0] = auto_run_q;
    tag_sr_d[0] = tag_q;
    for (int i = 1; i < REPORT_LAT; i++) begin
      run_sr_d[i] = run_sr_q[i-1];
      tag_sr_d[i] = tag_sr_q[i-1];
    end

    // Retire the delivered bit; pop the head once its vector is exhausted.
    if (rpt_hs) begin
      head_vec = q_q[0].vec & ~(NUM_REPORTS'(1) << rpt_id_q);
      q_d[0].vec = head_vec;
      if (head_vec == '0) begin
        for (int i = 0; i < PEND_DEPTH - 1; i++) q_d[i] = q_d[i+1];
        q_d[PEND_DEPTH-1] = '0;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (push && CNT_W'(i) == cnt_d) begin
        q_d[i].vec = auto_reports;
        q_d[i].tag = tag_sr_q[REPORT_LAT-1];
      end
    end
    cnt_d = cnt_d + CNT_W'(push);

    infl_d       = run_count(auto_run_d, run_sr_d);
    auto_reset_d = (state_d == ST_FLUSH);
    sym_ready_d  = (state_d == ST_STREAM) &&
                   ((32'(cnt_d) + 32'(infl_d)) < 32'(PEND_DEPTH));
    rpt_valid_d  = (cnt_d != '0);
    rpt_id_d     = rpt_valid_d ? low_bit(q_d[0].vec) : '0;
    rpt_seq_d    = rpt_valid_d ? q_d[0].tag : '0;
    busy_d       = (state_d != ST_STREAM) || (cnt_d != '0) || (infl_d != '0);
  end

  // State and output registers; reset drops all pending work and re-flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FLUSH;
      rcnt_q       <= '0;
      seq_q        <= '0;
      auto_run_q   <= 1'b0;
      sym_q        <= '0;
      tag_q        <= '0;
      run_sr_q     <= '0;
      for (int i = 0; i < REPORT_LAT; i++) tag_sr_q[i] <= '0;
      for (int i = 0; i < PEND_DEPTH; i++) q_q[i] <= '0;
      cnt_q        <= '0;
      sym_ready_q  <= 1'b0;
      auto_reset_q <= 1'b1;
      rpt_valid_q  <= 1'b0;
      rpt_id_q     <= '0;
      rpt_seq_q    <= '0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      seq_q        <= seq_d;
      auto_run_q   <= auto_run_d;
      sym_q        <= sym_d;
      tag_q        <= tag_d;
      run_sr_q     <= run_sr_d;
      tag_sr_q     <= tag_sr_d;
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      sym_ready_q  <= sym_ready_d;
      auto_reset_q <= auto_reset_d;
      rpt_valid_q  <= rpt_valid_d;
      rpt_id_q     <= rpt_id_d;
      rpt_seq_q    <= rpt_seq_d;
      busy_q       <= busy_d;
    end
  end

  assign sym_ready    = sym_ready_q;
  assign auto_run     = auto_run_q;
  assign auto_reset   = auto_reset_q;
  assign auto_symbols = sym_q;
  assign rpt_valid    = rpt_valid_q;
  assign rpt_id       = rpt_id_q;
  assign rpt_seq      = rpt_seq_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rm_stage_sequencer.sv
// Bench for rm_stage_sequencer: directed scenarios plus a randomized run,
// with a stage model and an expected-report queue kept by the bench.
module tb_rm_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = '0;
  logic        sym_last = 1'b0;
  logic        sym_ready;
  logic        flush_req = 1'b0;
  logic        auto_run;
  logic        auto_reset;
  logic [7:0]  auto_symbols;
  logic [19:0] auto_reports = '0;
  logic        rpt_valid;
  logic [4:0]  rpt_id;
  logic [15:0] rpt_seq;
  logic        rpt_ready = 1'b0;
  logic        busy;

  rm_stage_sequencer dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_last(sym_last), .sym_ready(sym_ready), .flush_req(flush_req),
    .auto_run(auto_run), .auto_reset(auto_reset), .auto_symbols(auto_symbols),
    .auto_reports(auto_reports), .rpt_valid(rpt_valid), .rpt_id(rpt_id),
    .rpt_seq(rpt_seq), .rpt_ready(rpt_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int seq; } rep_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] rep_tab [256];
  rep_t        exp_q [$];
  rep_t        obs_q [$];
  int          seq_m = 0;
  logic        exp_run = 1'b0;
  logic [7:0]  exp_sym = '0;
  logic        hold_v = 1'b0;
  logic        st_run = 1'b0;
  logic [7:0]  st_sym = '0;
  logic        noise_en = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Stage model: reports valid one cycle after the run strobe, junk otherwise.
  always @(posedge clk) begin
    #1;
    auto_reports = st_run ? rep_tab[st_sym] : (noise_en ? 20'($urandom) : 20'h0);
  end

  // Monitor and reference model: every accept expands into its report bits
  // in ascending order; reports must come out in exactly that order.
  always @(negedge clk) begin
    chk("run_reset_excl", 32'(auto_run && auto_reset), 0);
    chk("auto_run", 32'(auto_run), 32'(exp_run));
    if (exp_run) chk("auto_sym", 32'(auto_symbols), 32'(exp_sym));
    if (hold_v) chk("rpt_hold", 32'(rpt_valid), 1);
    st_run = auto_run;
    st_sym = auto_symbols;
    if (reset) begin
      exp_q.delete();
      seq_m   = 0;
      exp_run = 1'b0;
      hold_v  = 1'b0;
    end else begin
      exp_run = sym_valid && sym_ready;
      exp_sym = sym_data;
      if (sym_valid && sym_ready) begin
        for (int b = 0; b < 20; b++)
          if (rep_tab[sym_data][b]) exp_q.push_back('{b, seq_m});
        seq_m = (sym_last || flush_req) ? 0 : ((seq_m + 1) & 16'hFFFF);
      end
      if (rpt_valid && rpt_ready) begin
        obs_q.push_back('{int'(rpt_id), int'(rpt_seq)});
        chk("rpt_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("rpt_id", 32'(rpt_id), exp_q[0].id);
          chk("rpt_seq", 32'(rpt_seq), exp_q[0].seq);
          void'(exp_q.pop_front());
        end
      end
      hold_v = rpt_valid && !rpt_ready;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int   n = 0;
    logic got = 1'b0;
    sym_valid = 1'b1; sym_data = d; sym_last = l;
    while (!got && n < 50) begin
      @(negedge clk);
      got = sym_ready;
      cyc();
      n++;
    end
    sym_valid = 1'b0; sym_last = 1'b0;
    chk("send_accept", 32'(got), 1);
  endtask

  task automatic wait_ready(input int maxc);
    int n = 0;
    while (!sym_ready && n < maxc) begin cyc(); n++; end
    chk("wait_ready", 32'(sym_ready), 1);
  endtask

  task automatic wait_rpt(input int maxc);
    int n = 0;
    @(negedge clk);
    while (!rpt_valid && n < maxc) begin @(negedge clk); n++; end
    chk("wait_rpt", 32'(rpt_valid), 1);
  endtask

  initial begin
    int acc;
    int nrst;
    for (int i = 0; i < 256; i++) rep_tab[i] = '0;

    // Power-on reset and flush sequence.
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_sym_ready", 32'(sym_ready), 0);
    chk("rst_auto_run", 32'(auto_run), 0);
    chk("rst_auto_reset", 32'(auto_reset), 1);
    chk("rst_auto_sym", 32'(auto_symbols), 0);
    chk("rst_rpt_valid", 32'(rpt_valid), 0);
    chk("rst_rpt_id", 32'(rpt_id), 0);
    chk("rst_rpt_seq", 32'(rpt_seq), 0);
    chk("rst_busy", 32'(busy), 1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("c0_auto_reset", 32'(auto_reset), 1);
    chk("c0_sym_ready", 32'(sym_ready), 0);
    cyc(); @(negedge clk);
    chk("c1_auto_reset", 32'(auto_reset), 1);
    chk("c1_sym_ready", 32'(sym_ready), 0);
    cyc(); @(negedge clk);
    chk("c2_auto_reset", 32'(auto_reset), 0);
    chk("c2_sym_ready", 32'(sym_ready), 1);
    chk("c2_busy", 32'(busy), 0);
    cyc();

    // Back-to-back symbols without reports.
    for (int i = 0; i < 5; i++) begin
      sym_valid = 1'b1; sym_data = 8'(32'h11 + i); sym_last = (i == 4);
      @(negedge clk);
      chk("b2b_ready", 32'(sym_ready), 1);
      if (i > 0) begin
        chk("b2b_run", 32'(auto_run), 1);
        chk("b2b_sym", 32'(auto_symbols), 32'h10 + i);
      end
      cyc();
    end
    sym_valid = 1'b0; sym_last = 1'b0;
    @(negedge clk);
    chk("b2b_run_last", 32'(auto_run), 1);
    chk("b2b_sym_last", 32'(auto_symbols), 32'h15);
    for (int i = 0; i < 8; i++) begin
      cyc(); @(negedge clk);
      chk("b2b_no_rpt", 32'(rpt_valid), 0);
    end
    cyc();
    wait_ready(20);

    // Two report bits from symbol index 2, delivered in priority order.
    rep_tab[8'hA2] = 20'h00810;
    rpt_ready = 1'b1;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    wait_rpt(20);
    chk("two_bit_id0", 32'(rpt_id), 4);
    chk("two_bit_seq0", 32'(rpt_seq), 2);
    @(negedge clk);
    chk("two_bit_v1", 32'(rpt_valid), 1);
    chk("two_bit_id1", 32'(rpt_id), 11);
    chk("two_bit_seq1", 32'(rpt_seq), 2);
    @(negedge clk);
    chk("two_bit_done", 32'(rpt_valid), 0);
    cyc();
    wait_ready(20);

    // Back-pressure: consumer stalled, every symbol reports bit 0.
    for (int i = 0; i < 8; i++) rep_tab[8'hB0 + i] = 20'h1;
    rpt_ready = 1'b0;
    obs_q.delete();
    acc = 0;
    sym_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sym_data = 8'(32'hB0 + acc);
      @(negedge clk);
      if (sym_ready) acc++;
      cyc();
    end
    sym_valid = 1'b0;
    chk("bp_accepts", acc, 4);
    @(negedge clk);
    chk("bp_ready_low", 32'(sym_ready), 0);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_head_seq", 32'(rpt_seq), 0);
    cyc();
    rpt_ready = 1'b1;
    repeat (10) cyc();
    chk("bp_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk("bp_id", obs_q[i].id, 0);
      chk("bp_seq", obs_q[i].seq, i);
    end
    chk("bp_resume", 32'(sym_ready), 1);

    // Episode end with two reports pending.
    rep_tab[8'hC6] = 20'h4;
    rep_tab[8'hC7] = 20'h8;
    rpt_ready = 1'b0;
    obs_q.delete();
    send(8'hC4, 1'b0);
    send(8'hC5, 1'b0);
    send(8'hC6, 1'b0);
    send(8'hC7, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("drain_ready", 32'(sym_ready), 0);
      chk("drain_no_reset", 32'(auto_reset), 0);
      cyc();
    end
    @(negedge clk);
    chk("drain_head_id", 32'(rpt_id), 2);
    chk("drain_head_seq", 32'(rpt_seq), 6);
    cyc();
    rpt_ready = 1'b1;
    nrst = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (auto_reset) nrst++;
      cyc();
    end
    chk("drain_reset_cyc", nrst, 2);
    chk("drain_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("drain_id0", obs_q[0].id, 2);
      chk("drain_seq0", obs_q[0].seq, 6);
      chk("drain_id1", obs_q[1].id, 3);
      chk("drain_seq1", obs_q[1].seq, 7);
    end
    rep_tab[8'hD0] = 20'h20;
    wait_ready(20);
    send(8'hD0, 1'b0);
    wait_rpt(20);
    chk("new_ep_id", 32'(rpt_id), 5);
    chk("new_ep_seq", 32'(rpt_seq), 0);
    cyc();

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) rep_tab[8'hE0 + i] = 20'h82;
    rpt_ready = 1'b0;
    send(8'hE0, 1'b0);
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    repeat (5) cyc();
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_valid", 32'(rpt_valid), 1);
    obs_q.delete();
    cyc();
    reset = 1'b1;
    @(negedge clk);
    cyc();
    reset = 1'b0;
    rpt_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rpt_valid), 0);
    chk("mid_rst_reset0", 32'(auto_reset), 1);
    chk("mid_rst_ready0", 32'(sym_ready), 0);
    chk("mid_rst_busy", 32'(busy), 1);
    cyc(); @(negedge clk);
    chk("mid_rst_reset1", 32'(auto_reset), 1);
    chk("mid_rst_valid1", 32'(rpt_valid), 0);
    cyc(); @(negedge clk);
    chk("mid_rst_reset2", 32'(auto_reset), 0);
    chk("mid_rst_ready2", 32'(sym_ready), 1);
    chk("mid_rst_dropped", obs_q.size(), 0);
    cyc();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 256; i++)
      rep_tab[i] = ($urandom_range(2) == 0) ? 20'($urandom & $urandom) : 20'h0;
    noise_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      sym_valid = ($urandom_range(3) != 0);
      sym_data  = 8'($urandom);
      sym_last  = ($urandom_range(15) == 0);
      rpt_ready = ($urandom_range(2) != 0);
      flush_req = (sym_valid && sym_ready && $urandom_range(19) == 0) ||
                  (auto_reset && $urandom_range(1) == 0);
      cyc();
    end
    sym_valid = 1'b0; sym_last = 1'b0; flush_req = 1'b0; rpt_ready = 1'b1;
    acc = 0;
    while ((busy || exp_q.size() != 0) && acc < 200) begin cyc(); acc++; end
    chk("final_idle", 32'(busy), 0);
    chk("final_all_delivered", exp_q.size(), 0);
    chk("final_ready", 32'(sym_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
